// File: rtl/scan_sequencer.sv
// Row-scan controller for a 3-to-8 one-hot decoder: blank, dwell, advance, frame_done once per scan.
// Define SCAN_STEP_EN to add the single-row step input.
module scan_sequencer #(
    parameter int unsigned NUM_ROWS     = 8,
    parameter int unsigned DWELL_CYCLES = 8,
    parameter int unsigned BLANK_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [7:0] row_mask,
`ifdef SCAN_STEP_EN
    input  logic       step,
`endif
    output logic       sel_a,
    output logic       sel_b,
    output logic       sel_c,
    output logic       dec_en,
    output logic       busy,
    output logic       frame_done
);

    localparam int unsigned ROW_W   = 3;
    localparam int unsigned CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(NUM_ROWS - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } state_t;

    // With no blanking gap, a row starts directly in DRIVE.
    localparam state_t ENTRY = (BLANK_CYCLES == 0) ? DRIVE : BLANK;

    state_t           state, state_n;
    logic [ROW_W-1:0] row, row_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             single, single_n;
    logic             frame_n;

    // Next-state, row advance and frame pulse.
    always_comb begin
        state_n  = state;
        row_n    = row;
        cnt_n    = cnt;
        single_n = single;
        frame_n  = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (run) begin
                    state_n  = ENTRY;
                    single_n = 1'b0;
                end
`ifdef SCAN_STEP_EN
                else if (step) begin
                    state_n  = ENTRY;
                    single_n = 1'b1;
                end
`endif
            end
            BLANK: begin
                if (cnt == BLANK_LAST) begin
                    state_n = DRIVE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            DRIVE: begin
                if (cnt == DWELL_LAST) begin
                    cnt_n = '0;
                    if (row == LAST_ROW) begin
                        row_n   = '0;
                        frame_n = 1'b1;
                    end else begin
                        row_n = row + ROW_W'(1);
                    end
                    // A single-step row always returns to IDLE once complete.
                    if (run && !single) begin
                        state_n = ENTRY;
                    end else begin
                        state_n  = IDLE;
                        single_n = 1'b0;
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and registered outputs; dec_en follows the mask of the row being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            row        <= '0;
            cnt        <= '0;
            single     <= 1'b0;
            dec_en     <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            row        <= row_n;
            cnt        <= cnt_n;
            single     <= single_n;
            dec_en     <= (state_n == DRIVE) && row_mask[row_n];
            busy       <= (state_n != IDLE);
            frame_done <= frame_n;
        end
    end

    assign {sel_a, sel_b, sel_c} = row;

endmodule

// File: tb/tb_scan_sequencer.sv
// Scoreboard bench for scan_sequencer: default instance plus a 3-row, 1-cycle, no-blank instance.
module tb_scan_sequencer;

    typedef struct packed {
        logic [2:0] sel;
        logic       en;
        logic       busy;
        logic       done;
    } obs_t;

    logic       clk;
    logic       rst;
    logic       run;
    logic       run_f;
    logic [7:0] row_mask;
    logic       step;
    logic       sel_a, sel_b, sel_c, dec_en, busy, frame_done;
    logic       f_a, f_b, f_c, f_en, f_busy, f_done;

    obs_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    scan_sequencer u_dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .row_mask   (row_mask),
`ifdef SCAN_STEP_EN
        .step       (step),
`endif
        .sel_a      (sel_a),
        .sel_b      (sel_b),
        .sel_c      (sel_c),
        .dec_en     (dec_en),
        .busy       (busy),
        .frame_done (frame_done)
    );

    scan_sequencer #(
        .NUM_ROWS     (3),
        .DWELL_CYCLES (1),
        .BLANK_CYCLES (0)
    ) u_fast (
        .clk        (clk),
        .rst        (rst),
        .run        (run_f),
        .row_mask   (row_mask),
`ifdef SCAN_STEP_EN
        .step       (1'b0),
`endif
        .sel_a      (f_a),
        .sel_b      (f_b),
        .sel_c      (f_c),
        .dec_en     (f_en),
        .busy       (f_busy),
        .frame_done (f_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic obs_t mk(input int r, input bit en, input bit b, input bit d);
        obs_t o;
        o.sel  = 3'(r);
        o.en   = en;
        o.busy = b;
        o.done = d;
        return o;
    endfunction

    function automatic obs_t main_obs();
        return {sel_a, sel_b, sel_c, dec_en, busy, frame_done};
    endfunction

    function automatic obs_t fast_obs();
        return {f_a, f_b, f_c, f_en, f_busy, f_done};
    endfunction

    // Default timing: after the k-th edge from the run sample, row k/10, blank for k%10 < 2.
    function automatic obs_t scan_exp(input int k, input logic [7:0] mask);
        int r;
        r = (k / 10) % 8;
        return mk(r, ((k % 10) >= 2) && mask[r], 1'b1, (k > 0) && (k % 80 == 0));
    endfunction

    task automatic do_reset();
        rst   = 1'b1;
        run   = 1'b0;
        run_f = 1'b0;
        step  = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        obs_t e, o;
        rst = 1'b1; run = 1'b1; run_f = 1'b1; row_mask = 8'hFF;
        exp_q.push_back(mk(0, 1'b0, 1'b0, 1'b0));
        @(posedge clk); #1;
        e = exp_q.pop_front();
        o = main_obs(); checks++;
        if (o !== e) begin errors++; $display("FAIL reset_main got=%b exp=%b", o, e); end
        o = fast_obs(); checks++;
        if (o !== e) begin errors++; $display("FAIL reset_fast got=%b exp=%b", o, e); end
        rst = 1'b0; run = 1'b0; run_f = 1'b0;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(mk(0, 1'b0, 1'b0, 1'b0));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            o = main_obs(); checks++;
            if (o !== e) begin errors++; $display("FAIL idle_hold k=%0d got=%b exp=%b", k, o, e); end
        end
    endtask

    task automatic test_full_scan();
        obs_t e, o;
        do_reset();
        row_mask = 8'hFF;
        run = 1'b1;
        for (int k = 0; k <= 160; k++) begin
            exp_q.push_back(scan_exp(k, row_mask));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            o = main_obs(); checks++;
            if (o !== e) begin errors++; $display("FAIL full_scan k=%0d got=%b exp=%b", k, o, e); end
        end
    endtask

    task automatic test_mask();
        obs_t e, o;
        do_reset();
        row_mask = 8'b0000_0100;
        run = 1'b1;
        for (int k = 0; k <= 80; k++) begin
            exp_q.push_back(scan_exp(k, row_mask));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            o = main_obs(); checks++;
            if (o !== e) begin errors++; $display("FAIL mask k=%0d got=%b exp=%b", k, o, e); end
        end
    endtask

    task automatic test_run_drop();
        obs_t e, o;
        do_reset();
        row_mask = 8'hFF;
        run = 1'b1;
        for (int k = 0; k <= 63; k++) begin
            exp_q.push_back((k < 60) ? scan_exp(k, row_mask) : mk(6, 1'b0, 1'b0, 1'b0));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            o = main_obs(); checks++;
            if (o !== e) begin errors++; $display("FAIL run_drop k=%0d got=%b exp=%b", k, o, e); end
            if (k == 53) run = 1'b0;
        end
        run = 1'b1;
        for (int j = 0; j < 12; j++) begin
            exp_q.push_back(mk((j < 10) ? 6 : 7, (j % 10) >= 2, 1'b1, 1'b0));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            o = main_obs(); checks++;
            if (o !== e) begin errors++; $display("FAIL resume j=%0d got=%b exp=%b", j, o, e); end
        end
    endtask

    task automatic test_reset_mid();
        obs_t e, o;
        do_reset();
        row_mask = 8'hFF;
        run = 1'b1;
        for (int k = 0; k <= 35; k++) begin
            exp_q.push_back(scan_exp(k, row_mask));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            o = main_obs(); checks++;
            if (o !== e) begin errors++; $display("FAIL pre_rst k=%0d got=%b exp=%b", k, o, e); end
        end
        rst = 1'b1;
        for (int j = 0; j < 3; j++) begin
            if (j == 2) begin rst = 1'b0; run = 1'b0; end
            exp_q.push_back(mk(0, 1'b0, 1'b0, 1'b0));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            o = main_obs(); checks++;
            if (o !== e) begin errors++; $display("FAIL mid_rst j=%0d got=%b exp=%b", j, o, e); end
        end
    endtask

    task automatic test_no_blank();
        obs_t e, o;
        do_reset();
        row_mask = 8'hFF;
        run_f = 1'b1;
        for (int k = 0; k <= 12; k++) begin
            exp_q.push_back(mk(k % 3, 1'b1, 1'b1, (k > 0) && (k % 3 == 0)));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            o = fast_obs(); checks++;
            if (o !== e) begin errors++; $display("FAIL no_blank k=%0d got=%b exp=%b", k, o, e); end
        end
        run_f = 1'b0;
    endtask

`ifdef SCAN_STEP_EN
    task automatic test_step();
        obs_t e, o;
        do_reset();
        row_mask = 8'hFF;
        run = 1'b1;
        for (int k = 0; k <= 71; k++) begin
            exp_q.push_back((k < 70) ? scan_exp(k, row_mask) : mk(7, 1'b0, 1'b0, 1'b0));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            o = main_obs(); checks++;
            if (o !== e) begin errors++; $display("FAIL step_setup k=%0d got=%b exp=%b", k, o, e); end
            if (k == 64) run = 1'b0;
        end
        step = 1'b1;
        for (int j = 0; j < 12; j++) begin
            if (j < 10)       exp_q.push_back(mk(7, j >= 2, 1'b1, 1'b0));
            else if (j == 10) exp_q.push_back(mk(0, 1'b0, 1'b0, 1'b1));
            else              exp_q.push_back(mk(0, 1'b0, 1'b0, 1'b0));
            @(posedge clk); #1;
            step = 1'b0;
            e = exp_q.pop_front();
            o = main_obs(); checks++;
            if (o !== e) begin errors++; $display("FAIL step j=%0d got=%b exp=%b", j, o, e); end
        end
    endtask
`endif

    initial begin
        rst      = 1'b1;
        run      = 1'b0;
        run_f    = 1'b0;
        step     = 1'b0;
        row_mask = 8'hFF;
        test_reset();
        test_full_scan();
        test_mask();
        test_run_drop();
        test_reset_mid();
        test_no_blank();
`ifdef SCAN_STEP_EN
        test_step();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
